ysyx_040066_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order pipeline WB stage and
//  the long-latency multiplier and divider. Holds a per-register busy scoreboard for
//  in-flight mul/div destinations so decode can stall on RAW/WAW hazards.

---
 rtl/ysyx_040066_wb_arbiter_if.sv | 54 +++++
 rtl/ysyx_040066_wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_ysyx_040066_wb_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_040066_wb_arbiter_if.sv
// Bus bundle between EX/M/WB producers, decode and the register-file write arbiter.
// The perf counters exist only with YSYX_040066_WB_PERF_EN.
interface ysyx_040066_wb_arbiter_if #(
    parameter int XLEN = 64
);
    logic            pipe_valid;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_data;
    logic            mul_valid;
    logic [4:0]      mul_rd;
    logic [XLEN-1:0] mul_data;
    logic            mul_ready;
    logic            div_valid;
    logic [4:0]      div_rd;
    logic [XLEN-1:0] div_data;
    logic            div_ready;
    logic            stall_pipe;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic            iss_ready;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rf_wen;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_data;
`ifdef YSYX_040066_WB_PERF_EN
    logic [31:0]     perf_conflict;
    logic [31:0]     perf_starve;
`endif

    modport master (
        output pipe_valid, pipe_rd, pipe_data,
        output mul_valid, mul_rd, mul_data, div_valid, div_rd, div_data,
        output iss_valid, iss_rd, rs1, rs2,
        input  mul_ready, div_ready, stall_pipe, iss_ready, rs1_busy, rs2_busy,
`ifdef YSYX_040066_WB_PERF_EN
        input  perf_conflict, perf_starve,
`endif
        input  rf_wen, rf_rd, rf_data
    );

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data,
        input  mul_valid, mul_rd, mul_data, div_valid, div_rd, div_data,
        input  iss_valid, iss_rd, rs1, rs2,
        output mul_ready, div_ready, stall_pipe, iss_ready, rs1_busy, rs2_busy,
`ifdef YSYX_040066_WB_PERF_EN
        output perf_conflict, perf_starve,
`endif
        output rf_wen, rf_rd, rf_data
    );
endinterface

// File: rtl/ysyx_040066_wb_arbiter.sv
// Register-file write-port arbiter (pipe > round-robin mul/div) with mul/div busy scoreboard.
// Optional perf counters: define YSYX_040066_WB_PERF_EN.
module ysyx_040066_wb_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4,
    parameter int STARVE_W     = 3
) (
    input logic                      clk,
    input logic                      rst,
    ysyx_040066_wb_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {G_NONE, G_PIPE, G_MUL, G_DIV} grant_e;
    typedef enum logic {RR_MUL, RR_DIV} rr_e;

    localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_LIMIT - 1);

    rr_e             rr, rr_next;
    grant_e          grant;
    logic [4:0]      grant_rd;
    logic [XLEN-1:0] grant_data;
    logic [STARVE_W-1:0] mul_cnt, div_cnt;
    logic            starved_mul, starved_div;
    logic            mul_acc, div_acc, mul_wait, div_wait, mul_set, div_set;
    logic [31:0]     busy;

    always_ff @(posedge clk) begin
        if (rst) rr <= RR_MUL;
        else     rr <= rr_next;
    end

    always_comb begin
        rr_next = rr;
        if (grant == G_MUL)      rr_next = RR_DIV;
        else if (grant == G_DIV) rr_next = RR_MUL;
    end

    // A starved unit outranks the pipe so stall_pipe is guaranteed to release.
    always_comb begin
        grant = G_NONE;
        if (starved_mul && bus.mul_valid && starved_div && bus.div_valid)
            grant = (rr == RR_MUL) ? G_MUL : G_DIV;
        else if (starved_mul && bus.mul_valid)
            grant = G_MUL;
        else if (starved_div && bus.div_valid)
            grant = G_DIV;
        else if (bus.pipe_valid)
            grant = G_PIPE;
        else if (bus.mul_valid && bus.div_valid)
            grant = (rr == RR_MUL) ? G_MUL : G_DIV;
        else if (bus.mul_valid)
            grant = G_MUL;
        else if (bus.div_valid)
            grant = G_DIV;
    end

    always_comb begin
        grant_rd   = '0;
        grant_data = '0;
        case (grant)
            G_PIPE: begin grant_rd = bus.pipe_rd; grant_data = bus.pipe_data; end
            G_MUL:  begin grant_rd = bus.mul_rd;  grant_data = bus.mul_data;  end
            G_DIV:  begin grant_rd = bus.div_rd;  grant_data = bus.div_data;  end
            default: ;
        endcase
    end

    assign bus.mul_ready = (grant == G_MUL);
    assign bus.div_ready = (grant == G_DIV);
    assign mul_acc  = bus.mul_valid && bus.mul_ready;
    assign div_acc  = bus.div_valid && bus.div_ready;
    assign mul_wait = bus.mul_valid && !bus.mul_ready;
    assign div_wait = bus.div_valid && !bus.div_ready;
    assign mul_set  = mul_wait && (mul_cnt == STARVE_LAST);
    assign div_set  = div_wait && (div_cnt == STARVE_LAST);
    assign bus.stall_pipe = starved_mul || starved_div;

    // Counters saturate at the threshold so a misbehaving pipe cannot wrap them back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_cnt     <= '0;
            div_cnt     <= '0;
            starved_mul <= 1'b0;
            starved_div <= 1'b0;
        end else begin
            if (mul_acc)                            mul_cnt <= '0;
            else if (mul_wait && !(mul_cnt == STARVE_LAST)) mul_cnt <= mul_cnt + 1'b1;
            if (div_acc)                            div_cnt <= '0;
            else if (div_wait && !(div_cnt == STARVE_LAST)) div_cnt <= div_cnt + 1'b1;
            if (mul_acc)      starved_mul <= 1'b0;
            else if (mul_set) starved_mul <= 1'b1;
            if (div_acc)      starved_div <= 1'b0;
            else if (div_set) starved_div <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rf_wen  <= 1'b0;
            bus.rf_rd   <= '0;
            bus.rf_data <= '0;
        end else begin
            bus.rf_wen <= (grant != G_NONE) && (grant_rd != 5'd0);
            if (grant != G_NONE) begin
                bus.rf_rd   <= grant_rd;
                bus.rf_data <= grant_data;
            end
        end
    end

    // Later assignment wins, so an issue to the same rd overrides a completing write.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (mul_acc) busy[bus.mul_rd] <= 1'b0;
            if (div_acc) busy[bus.div_rd] <= 1'b0;
            if (bus.iss_valid && bus.iss_ready && bus.iss_rd != 5'd0) busy[bus.iss_rd] <= 1'b1;
            busy[0] <= 1'b0;
        end
    end

    assign bus.iss_ready = !busy[bus.iss_rd];
    assign bus.rs1_busy  = busy[bus.rs1];
    assign bus.rs2_busy  = busy[bus.rs2];

`ifdef YSYX_040066_WB_PERF_EN
    logic [1:0] n_req;
    assign n_req = 2'(bus.pipe_valid) + 2'(bus.mul_valid) + 2'(bus.div_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.perf_conflict <= '0;
            bus.perf_starve   <= '0;
        end else begin
            if (n_req >= 2'd2) bus.perf_conflict <= bus.perf_conflict + 32'd1;
            if (!bus.stall_pipe && (mul_set || div_set)) bus.perf_starve <= bus.perf_starve + 32'd1;
        end
    end
`endif

    a_no_pipe_during_stall: assert property (@(posedge clk) disable iff (rst)
        !(bus.pipe_valid && bus.stall_pipe));
endmodule

// File: tb/tb_ysyx_040066_wb_arbiter.sv
// Directed self-checking bench for the register-file write arbiter.
module tb_ysyx_040066_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ysyx_040066_wb_arbiter_if #(.XLEN(64)) bus ();
    ysyx_040066_wb_arbiter #(.XLEN(64), .STARVE_LIMIT(4), .STARVE_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.pipe_valid = 1'b0; bus.pipe_rd = '0; bus.pipe_data = '0;
        bus.mul_valid  = 1'b0; bus.mul_rd  = '0; bus.mul_data  = '0;
        bus.div_valid  = 1'b0; bus.div_rd  = '0; bus.div_data  = '0;
        bus.iss_valid  = 1'b0; bus.iss_rd  = '0;
        bus.rs1 = '0; bus.rs2 = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        bus.rs1 = 5'd7; bus.iss_rd = 5'd7;
        #1;
        checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL reset_wen got=%0b exp=0", bus.rf_wen); end
        checks++; if (bus.rf_rd !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", bus.rf_rd); end
        checks++; if (bus.rf_data !== 64'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", bus.rf_data); end
        checks++; if (bus.stall_pipe !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", bus.stall_pipe); end
        checks++; if (bus.rs1_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.rs1_busy); end
        checks++; if (bus.iss_ready !== 1'b1) begin failures++; $display("FAIL reset_iss_ready got=%0b exp=1", bus.iss_ready); end
        clear_inputs();
    endtask

    task automatic test_pipe_write();
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd5; bus.pipe_data = 64'h11;
        step();
        bus.pipe_valid = 1'b0;
        checks++; if (bus.rf_wen !== 1'b1) begin failures++; $display("FAIL pipe_wen got=%0b exp=1", bus.rf_wen); end
        checks++; if (bus.rf_rd !== 5'd5) begin failures++; $display("FAIL pipe_rd got=%0d exp=5", bus.rf_rd); end
        checks++; if (bus.rf_data !== 64'h11) begin failures++; $display("FAIL pipe_data got=%0h exp=11", bus.rf_data); end
        step();
        checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL pipe_idle_wen got=%0b exp=0", bus.rf_wen); end
    endtask

    task automatic test_round_robin();
        bus.mul_valid = 1'b1; bus.mul_rd = 5'd3; bus.mul_data = 64'h33;
        bus.div_valid = 1'b1; bus.div_rd = 5'd4; bus.div_data = 64'h44;
        #1;
        checks++; if (bus.mul_ready !== 1'b1) begin failures++; $display("FAIL rr_mul_first got=%0b exp=1", bus.mul_ready); end
        checks++; if (bus.div_ready !== 1'b0) begin failures++; $display("FAIL rr_div_wait got=%0b exp=0", bus.div_ready); end
        step();
        bus.mul_valid = 1'b0;
        #1;
        checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd3 || bus.rf_data !== 64'h33) begin
            failures++; $display("FAIL rr_write_mul got=%0b/%0d/%0h exp=1/3/33", bus.rf_wen, bus.rf_rd, bus.rf_data); end
        checks++; if (bus.div_ready !== 1'b1) begin failures++; $display("FAIL rr_div_second got=%0b exp=1", bus.div_ready); end
        step();
        bus.div_valid = 1'b0;
        checks++; if (bus.rf_wen !== 1'b1 || bus.rf_rd !== 5'd4 || bus.rf_data !== 64'h44) begin
            failures++; $display("FAIL rr_write_div got=%0b/%0d/%0h exp=1/4/44", bus.rf_wen, bus.rf_rd, bus.rf_data); end
        step();
    endtask

    task automatic test_starvation();
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd1; bus.pipe_data = 64'hA0;
        bus.mul_valid  = 1'b1; bus.mul_rd  = 5'd2; bus.mul_data  = 64'h55;
        #1;
        checks++; if (bus.mul_ready !== 1'b0) begin failures++; $display("FAIL starve_pipe_wins got=%0b exp=0", bus.mul_ready); end
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++;
            if (bus.stall_pipe !== (i == 4)) begin
                failures++; $display("FAIL starve_stall_c%0d got=%0b exp=%0b", i, bus.stall_pipe, (i == 4));
            end
        end
        bus.pipe_valid = 1'b0;
        #1;
        checks++; if (bus.mul_ready !== 1'b1) begin failures++; $display("FAIL starve_mul_grant got=%0b exp=1", bus.mul_ready); end
        step();
        bus.mul_valid = 1'b0;
        checks++; if (bus.stall_pipe !== 1'b0) begin failures++; $display("FAIL starve_release got=%0b exp=0", bus.stall_pipe); end
        checks++; if (bus.rf_rd !== 5'd2 || bus.rf_data !== 64'h55) begin
            failures++; $display("FAIL starve_write got=%0d/%0h exp=2/55", bus.rf_rd, bus.rf_data); end
        step();
    endtask

    task automatic test_scoreboard();
        bus.rs1 = 5'd7; bus.rs2 = 5'd8;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
        #1;
        checks++; if (bus.iss_ready !== 1'b1) begin failures++; $display("FAIL sb_iss_ready got=%0b exp=1", bus.iss_ready); end
        step();
        bus.iss_valid = 1'b0;
        #1;
        checks++; if (bus.rs1_busy !== 1'b1) begin failures++; $display("FAIL sb_rs1_busy got=%0b exp=1", bus.rs1_busy); end
        checks++; if (bus.rs2_busy !== 1'b0) begin failures++; $display("FAIL sb_rs2_free got=%0b exp=0", bus.rs2_busy); end
        checks++; if (bus.iss_ready !== 1'b0) begin failures++; $display("FAIL sb_iss_blocked got=%0b exp=0", bus.iss_ready); end
        bus.mul_valid = 1'b1; bus.mul_rd = 5'd7; bus.mul_data = 64'h77;
        step();
        bus.mul_valid = 1'b0;
        #1;
        checks++; if (bus.rs1_busy !== 1'b0) begin failures++; $display("FAIL sb_clear got=%0b exp=0", bus.rs1_busy); end
        checks++; if (bus.rf_rd !== 5'd7 || bus.rf_data !== 64'h77) begin
            failures++; $display("FAIL sb_mul_write got=%0d/%0h exp=7/77", bus.rf_rd, bus.rf_data); end
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd0; bus.rs1 = 5'd0;
        step();
        bus.iss_valid = 1'b0;
        #1;
        checks++; if (bus.rs1_busy !== 1'b0) begin failures++; $display("FAIL sb_x0 got=%0b exp=0", bus.rs1_busy); end
    endtask

    task automatic test_set_wins();
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
        bus.div_valid = 1'b1; bus.div_rd = 5'd9; bus.div_data = 64'h99;
        #1;
        checks++; if (bus.div_ready !== 1'b1) begin failures++; $display("FAIL sw_div_ready got=%0b exp=1", bus.div_ready); end
        step();
        bus.iss_valid = 1'b0; bus.div_valid = 1'b0; bus.rs2 = 5'd9;
        #1;
        checks++; if (bus.rs2_busy !== 1'b1) begin failures++; $display("FAIL sw_busy9 got=%0b exp=1", bus.rs2_busy); end
    endtask

    task automatic test_rd0_and_reset();
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd0; bus.pipe_data = 64'hFF;
        step();
        checks++; if (bus.rf_wen !== 1'b0) begin failures++; $display("FAIL rd0_wen got=%0b exp=0", bus.rf_wen); end
        bus.pipe_valid = 1'b0;
        bus.iss_valid = 1'b1; bus.iss_rd = 5'd12;
        step();
        bus.iss_valid = 1'b0;
        bus.rs1 = 5'd12;
        #1;
        checks++; if (bus.rs1_busy !== 1'b1) begin failures++; $display("FAIL rst_pre_busy got=%0b exp=1", bus.rs1_busy); end
        bus.pipe_valid = 1'b1; bus.pipe_rd = 5'd6; bus.pipe_data = 64'h22;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.pipe_valid = 1'b0;
        #1;
        checks++; if (bus.rf_wen !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_data !== 64'd0) begin
            failures++; $display("FAIL rst_rf got=%0b/%0d/%0h exp=0/0/0", bus.rf_wen, bus.rf_rd, bus.rf_data); end
        checks++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            failures++; $display("FAIL rst_busy got=%0b/%0b exp=0/0", bus.rs1_busy, bus.rs2_busy); end
        checks++; if (bus.stall_pipe !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", bus.stall_pipe); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_pipe_write();
        test_round_robin();
        test_starvation();
        test_scoreboard();
        test_set_wins();
        test_rd0_and_reset();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
